// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit R/W registers with independent
// write/read channels (one outstanding each) and a parallel copy of all registers.
module axi4lite_reg_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NUM_REGS*DW-1:0] r_regs;
  logic                   r_aw_held;
  logic                   r_w_held;
  logic [IW-1:0]          r_aw_idx;
  logic [DW-1:0]          r_w_data;
  logic [NB-1:0]          r_w_strb;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic                   r_rvalid;
  logic [1:0]             r_rresp;
  logic [DW-1:0]          r_rdata;

  logic                   w_awready;
  logic                   w_wready;
  logic                   w_arready;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_ar_hs;
  logic                   w_commit;
  logic [IW-1:0]          w_wr_idx;
  logic [IW-1:0]          w_rd_idx;
  logic [DW-1:0]          w_wr_data;
  logic [NB-1:0]          w_wr_strb;
  logic [NUM_REGS-1:0]    w_wr_sel;
  logic                   w_wr_hit;
  logic                   w_rd_hit;
  logic [DW-1:0]          w_rd_data;
  logic                   w_unused;

  assign w_awready = !r_aw_held && !r_bvalid && !ARESET;
  assign w_wready  = !r_w_held && !r_bvalid && !ARESET;
  assign w_arready = !r_rvalid && !ARESET;
  assign w_aw_hs   = S_AXI_AWVALID && w_awready;
  assign w_w_hs    = S_AXI_WVALID && w_wready;
  assign w_ar_hs   = S_AXI_ARVALID && w_arready;

  // The held half (if any) merges with the half arriving this cycle.
  assign w_commit  = (w_aw_hs || r_aw_held) && (w_w_hs || r_w_held);
  assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wr_data = r_w_held ? r_w_data : S_AXI_WDATA;
  assign w_wr_strb = r_w_held ? r_w_strb : S_AXI_WSTRB;
  assign w_rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wr_hit  = |w_wr_sel;

  always_comb begin
    w_wr_sel  = '0;
    w_rd_data = '0;
    w_rd_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (w_wr_idx == IW'(k)) w_wr_sel[k] = 1'b1;
      if (w_rd_idx == IW'(k)) begin
        w_rd_data = r_regs[k*DW +: DW];
        w_rd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_regs <= '0;
    end else if (w_commit) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (w_wr_sel[k] && w_wr_strb[b]) r_regs[k*DW + b*8 +: 8] <= w_wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
      if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign regs_out      = r_regs;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
